// File: rtl/life_vga_render.sv
// ============================================================================
// life_vga_render
// ----------------------------------------------------------------------------
// VGA display stage for the 16x16 Game of Life board. It produces a
// 640x480 @ 60 Hz raster and draws each cell as a 16x16 pixel square. The
// board sits at (X0, Y0), which is centred on screen by default.
//
// The map and the cursor position are snapshotted once per frame, on the last
// pixel of the last line. Changes to the inputs during a frame therefore
// never produce a mixed image.
//
// Optional feature macro: LIFE_VGA_GRID_EN
//   defined     -> the top row and left column of every cell are drawn as a
//                  dark grid line (8'h24). The cursor outline still takes
//                  priority over the grid.
//   not defined -> no grid, and live cells are solid green blocks.
//
// Parameters:
//   CLK_DIV  system clocks per pixel (>= 2); 100 MHz / 4 = 25 MHz pixel rate
//   X0, Y0   first board pixel column / row
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   map          in   256 cell states, cell (x,y) = map[y*16+x], 1 = alive
//   cursor_x     in   cursor column 0..15
//   cursor_y     in   cursor row 0..15
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   rgb          out  pixel colour RRRGGGBB
//   frame_start  out  one-clk pulse in the cycle after the snapshot loads
//
// Outputs are registered on the pixel enable from the current (h, v). They
// lag the counters by one pixel period and hold between pixel enables.
// ============================================================================
module life_vga_render #(
    parameter int CLK_DIV = 4,
    parameter int X0      = 192,
    parameter int Y0      = 112
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] map,
    input  logic [3:0]   cursor_x,
    input  logic [3:0]   cursor_y,
    output logic         hsync,
    output logic         vsync,
    output logic [7:0]   rgb,
    output logic         frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             h_last;
    logic             v_last;
    logic             snap_en;
    logic [255:0]     snap;
    logic [3:0]       cur_x;
    logic [3:0]       cur_y;

    assign pix_en  = (div == DIV_W'(CLK_DIV - 1));
    assign h_last  = (h == 10'd799);
    assign v_last  = (v == 10'd524);
    assign snap_en = pix_en && h_last && v_last;

    // ------------------------------------------------------------------
    // Pixel clock divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Raster counters: h 0..799, v 0..524
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-frame snapshot of the map and cursor, taken on the final pixel
    // of the frame so that the whole next frame sees one consistent board.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap  <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (snap_en) begin
            snap  <= map;
            cur_x <= cursor_x;
            cur_y <= cursor_y;
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour for the current (h, v)
    // ------------------------------------------------------------------
    logic [9:0] bx;
    logic [9:0] by;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] ox;
    logic [3:0] oy;
    logic       visible;
    logic       in_board;
    logic       on_cursor;
    logic       cursor_edge;
    logic       cell_alive;
    logic [7:0] pix_colour;

    // Left of / above the board the subtraction wraps to a large value,
    // so a single unsigned compare covers both sides of the board.
    assign bx          = h - 10'(X0);
    assign by          = v - 10'(Y0);
    assign col         = bx[7:4];
    assign row         = by[7:4];
    assign ox          = bx[3:0];
    assign oy          = by[3:0];
    assign visible     = (h < 10'd640) && (v < 10'd480);
    assign in_board    = (bx < 10'd256) && (by < 10'd256);
    assign on_cursor   = (col == cur_x) && (row == cur_y);
    assign cursor_edge = (ox == 4'd0) || (ox == 4'd15) ||
                         (oy == 4'd0) || (oy == 4'd15);
    // {row, col} is row*16+col without a multiplier
    assign cell_alive  = snap[{row, col}];

    always_comb begin
        pix_colour = 8'h00;
        if (!visible) begin
            pix_colour = 8'h00;
        end else if (!in_board) begin
            pix_colour = 8'h49;
        end else if (on_cursor && cursor_edge) begin
            pix_colour = 8'hE0;
`ifdef LIFE_VGA_GRID_EN
        end else if ((ox == 4'd0) || (oy == 4'd0)) begin
            pix_colour = 8'h24;
`endif
        end else if (cell_alive) begin
            pix_colour = 8'h1C;
        end else begin
            pix_colour = 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. Sync and colour come from the same (h, v), so
    // they stay aligned. frame_start is updated every clk, which makes it
    // exactly one clk wide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            rgb         <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_en;
            if (pix_en) begin
                hsync <= !((h >= 10'd656) && (h <= 10'd751));
                vsync <= !((v >= 10'd490) && (v <= 10'd491));
                rgb   <= pix_colour;
            end
        end
    end

endmodule
